// File: rtl/reward_fetch_pkg.sv
// Shared constants and state/field encodings for the reward-stage neighbour-table fetcher.
package reward_fetch_pkg;

    localparam int unsigned DEFAULT_WORD_WIDTH    = 16;
    localparam int unsigned DEFAULT_ADDR_WIDTH    = 11;
    localparam int unsigned DEFAULT_NUM_NEIGHBORS = 32;
    localparam int unsigned DEFAULT_RD_LATENCY    = 1;
    localparam int unsigned DEFAULT_STRIDE        = 2;

    localparam logic [10:0] DEFAULT_BASE_NBR_ID = 11'h048;
    localparam logic [10:0] DEFAULT_BASE_BATT   = 11'h148;
    localparam logic [10:0] DEFAULT_BASE_QVAL   = 11'h1C8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FETCH = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

    // Fields are fetched in this order; the encoding doubles as the field counter.
    typedef enum logic [1:0] {
        FIELD_BATT = 2'd0,
        FIELD_QVAL = 2'd1,
        FIELD_NBR  = 2'd2
    } field_t;

endpackage

// File: rtl/reward_fetch.sv
// Fetches batteryStat[besthop], qValue[besthop] and neighborID[action] over a shared
// memory read port with configurable read latency and index range checking.
module reward_fetch
    import reward_fetch_pkg::*;
#(
    parameter int unsigned WORD_WIDTH    = DEFAULT_WORD_WIDTH,
    parameter int unsigned ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
    parameter int unsigned NUM_NEIGHBORS = DEFAULT_NUM_NEIGHBORS,
    parameter int unsigned RD_LATENCY    = DEFAULT_RD_LATENCY,
    parameter logic [ADDR_WIDTH-1:0] BASE_NBR_ID = ADDR_WIDTH'(DEFAULT_BASE_NBR_ID),
    parameter logic [ADDR_WIDTH-1:0] BASE_BATT   = ADDR_WIDTH'(DEFAULT_BASE_BATT),
    parameter logic [ADDR_WIDTH-1:0] BASE_QVAL   = ADDR_WIDTH'(DEFAULT_BASE_QVAL),
    parameter int unsigned STRIDE        = DEFAULT_STRIDE
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] action,
    input  logic [WORD_WIDTH-1:0] besthop,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [WORD_WIDTH-1:0] out_batteryStat,
    output logic [WORD_WIDTH-1:0] out_Value,
    output logic [WORD_WIDTH-1:0] out_destinationID,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned WAIT_W = $clog2(RD_LATENCY + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_LATENCY - 1);

    fetch_state_t            state_q;
    fetch_state_t            state_d;
    field_t                  field_q;
    logic [WAIT_W-1:0]       wait_q;
    logic [WORD_WIDTH-1:0]   besthop_q;
    logic [WORD_WIDTH-1:0]   action_q;
    logic                    err_pending_q;
    logic                    accept;
    logic                    idx_bad;
    logic                    capture;

    // Table address of one field: base of its table plus the scaled neighbour index.
    function automatic logic [ADDR_WIDTH-1:0] field_addr(
        input field_t                f,
        input logic [WORD_WIDTH-1:0] bh,
        input logic [WORD_WIDTH-1:0] act
    );
        logic [ADDR_WIDTH-1:0] base;
        logic [WORD_WIDTH-1:0] idx;
        case (f)
            FIELD_BATT: begin base = BASE_BATT; idx = bh;  end
            FIELD_QVAL: begin base = BASE_QVAL; idx = bh;  end
            default:    begin base = BASE_NBR_ID; idx = act; end
        endcase
        return ADDR_WIDTH'(64'(base) + 64'(idx) * 64'(STRIDE));
    endfunction

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        idx_bad = (32'(besthop) >= NUM_NEIGHBORS) || (32'(action) >= NUM_NEIGHBORS);
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = idx_bad ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (wait_q == '0) begin
                    capture = 1'b1;
                    if (field_q == FIELD_NBR) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = en ? ST_ARMED : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A rejected request never touches the address or the fetched fields.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            field_q           <= FIELD_BATT;
            wait_q            <= '0;
            besthop_q         <= '0;
            action_q          <= '0;
            err_pending_q     <= 1'b0;
            address           <= '0;
            out_batteryStat   <= '0;
            out_Value         <= '0;
            out_destinationID <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            if (accept) begin
                besthop_q     <= besthop;
                action_q      <= action;
                busy          <= 1'b1;
                err_pending_q <= idx_bad;
                if (!idx_bad) begin
                    field_q <= FIELD_BATT;
                    wait_q  <= WAIT_LOAD;
                    address <= field_addr(FIELD_BATT, besthop, action);
                end
            end

            if (capture) begin
                case (field_q)
                    FIELD_BATT: out_batteryStat   <= data_in;
                    FIELD_QVAL: out_Value         <= data_in;
                    default:    out_destinationID <= data_in;
                endcase
                if (field_q != FIELD_NBR) begin
                    field_q <= field_t'(field_q + 2'd1);
                    wait_q  <= WAIT_LOAD;
                    address <= field_addr(field_t'(field_q + 2'd1), besthop_q, action_q);
                end
            end else if (state_q == ST_FETCH) begin
                wait_q <= wait_q - WAIT_W'(1);
            end

            if (state_q == ST_DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
                err  <= err_pending_q;
            end
        end
    end

endmodule
